// File: rtl/debug_link_pkg.sv
// Shared constants and types for the host debug link front-end.
// Command/reply byte values, link owner and arbiter state encodings.
package debug_link_pkg;

  localparam logic [7:0] CMD_LOAD_IMEM = 8'h1C;
  localparam logic [7:0] CMD_LOAD_DMEM = 8'h1D;
  localparam logic [7:0] CMD_EXEC      = 8'hE0;
  localparam logic [7:0] REPLY_ACK     = 8'hAC;
  localparam logic [7:0] REPLY_NAK     = 8'hEE;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_LDR,
    OWN_EXE
  } owner_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REPLY,
    S_WAIT_TX,
    S_GRANT_LDR,
    S_GRANT_EXE,
    S_RELEASE
  } state_e;

  // Which client a command byte hands the link to; OWN_NONE means unknown command.
  function automatic owner_e cmd_owner(input logic [7:0] cmd);
    owner_e own;
    case (cmd)
      CMD_LOAD_IMEM,
      CMD_LOAD_DMEM: own = OWN_LDR;
      CMD_EXEC:      own = OWN_EXE;
      default:       own = OWN_NONE;
    endcase
    return own;
  endfunction

  function automatic logic [7:0] cmd_reply(input logic [7:0] cmd);
    return (cmd_owner(cmd) == OWN_NONE) ? REPLY_NAK : REPLY_ACK;
  endfunction

endpackage

// File: rtl/host_command_arbiter.sv
// Decodes one host command byte, replies ACK/NAK, then hands the UART link to the loader
// or execution controller until its done pulse; RX gating and TX muxing follow the state.
module host_command_arbiter
  import debug_link_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_ready_i,
  output logic [7:0] tx_data_o,
  output logic       tx_start_o,
  input  logic       tx_done_i,
  output logic       ldr_grant_o,
  output logic       ldr_target_o,
  output logic       ldr_rx_ready_o,
  input  logic [7:0] ldr_tx_data_i,
  input  logic       ldr_tx_start_i,
  input  logic       ldr_done_i,
  output logic       exe_grant_o,
  output logic       exe_rx_ready_o,
  input  logic [7:0] exe_tx_data_i,
  input  logic       exe_tx_start_i,
  input  logic       exe_done_i,
  output logic       busy_o
);

  state_e     state_q, state_d;
  logic [7:0] cmd_q;
  logic       target_q;
  owner_e     owner;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      cmd_q    <= 8'h00;
      target_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && rx_ready_i) begin
        cmd_q <= rx_data_i;
      end
      // Target is captured once on grant entry so it stays stable for the whole grant.
      if (state_q == S_WAIT_TX && tx_done_i && cmd_owner(cmd_q) == OWN_LDR) begin
        target_q <= (cmd_q == CMD_LOAD_DMEM);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner   = OWN_NONE;
    case (state_q)
      S_IDLE: begin
        if (rx_ready_i) state_d = S_REPLY;
      end
      S_REPLY: begin
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done_i) begin
          case (cmd_owner(cmd_q))
            OWN_LDR: state_d = S_GRANT_LDR;
            OWN_EXE: state_d = S_GRANT_EXE;
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_GRANT_LDR: begin
        owner = OWN_LDR;
        if (ldr_done_i) state_d = S_RELEASE;
      end
      S_GRANT_EXE: begin
        owner = OWN_EXE;
        if (exe_done_i) state_d = S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output mux: reply byte while answering the host, owner's TX path while granted.
  always_comb begin
    tx_data_o      = 8'h00;
    tx_start_o     = 1'b0;
    ldr_rx_ready_o = 1'b0;
    exe_rx_ready_o = 1'b0;
    case (owner)
      OWN_LDR: begin
        tx_data_o      = ldr_tx_data_i;
        tx_start_o     = ldr_tx_start_i;
        ldr_rx_ready_o = rx_ready_i;
      end
      OWN_EXE: begin
        tx_data_o      = exe_tx_data_i;
        tx_start_o     = exe_tx_start_i;
        exe_rx_ready_o = rx_ready_i;
      end
      default: begin
        if (state_q == S_REPLY || state_q == S_WAIT_TX) begin
          tx_data_o = cmd_reply(cmd_q);
        end
        tx_start_o = (state_q == S_REPLY);
      end
    endcase
  end

  assign ldr_grant_o  = (owner == OWN_LDR);
  assign exe_grant_o  = (owner == OWN_EXE);
  assign ldr_target_o = target_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_host_command_arbiter.sv
// Directed bench: expected TX bytes and forwarded RX bytes go into queues; a negedge
// monitor pops and compares whenever the DUT strobes tx_start_o or a gated rx_ready.
module tb_host_command_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] rx_data_i = 8'h00;
  logic       rx_ready_i = 1'b0;
  logic [7:0] tx_data_o;
  logic       tx_start_o;
  logic       tx_done_i = 1'b0;
  logic       ldr_grant_o, ldr_target_o, ldr_rx_ready_o;
  logic [7:0] ldr_tx_data_i = 8'h00;
  logic       ldr_tx_start_i = 1'b0;
  logic       ldr_done_i = 1'b0;
  logic       exe_grant_o, exe_rx_ready_o;
  logic [7:0] exe_tx_data_i = 8'h00;
  logic       exe_tx_start_i = 1'b0;
  logic       exe_done_i = 1'b0;
  logic       busy_o;

  int total = 0;
  int bad = 0;
  logic [7:0] txq[$];
  logic [7:0] ldrq[$];
  logic [7:0] exeq[$];

  host_command_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_data_i(rx_data_i), .rx_ready_i(rx_ready_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
    .ldr_grant_o(ldr_grant_o), .ldr_target_o(ldr_target_o), .ldr_rx_ready_o(ldr_rx_ready_o),
    .ldr_tx_data_i(ldr_tx_data_i), .ldr_tx_start_i(ldr_tx_start_i), .ldr_done_i(ldr_done_i),
    .exe_grant_o(exe_grant_o), .exe_rx_ready_o(exe_rx_ready_o),
    .exe_tx_data_i(exe_tx_data_i), .exe_tx_start_i(exe_tx_start_i), .exe_done_i(exe_done_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk_i) begin
    if (rst_ni && tx_start_o) begin
      if (txq.size() == 0) check("tx_unexpected", 8'h01, 8'h00);
      else check("tx_byte", tx_data_o, txq.pop_front());
    end
    if (rst_ni && ldr_rx_ready_o) begin
      if (ldrq.size() == 0) check("ldr_rx_unexpected", 8'h01, 8'h00);
      else check("ldr_rx_byte", rx_data_i, ldrq.pop_front());
    end
    if (rst_ni && exe_rx_ready_o) begin
      if (exeq.size() == 0) check("exe_rx_unexpected", 8'h01, 8'h00);
      else check("exe_rx_byte", rx_data_i, exeq.pop_front());
    end
    if (ldr_grant_o && exe_grant_o) check("grant_exclusive", 8'h01, 8'h00);
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] d);
    rx_data_i = d;
    rx_ready_i = 1'b1;
    cyc();
    rx_ready_i = 1'b0;
  endtask

  // Host sends command byte, waits for the reply strobe, then the UART finishes it.
  task automatic send_cmd(input logic [7:0] d, input logic [7:0] reply);
    bit seen = 0;
    txq.push_back(reply);
    pulse_rx(d);
    for (int i = 0; i < 3; i++) begin
      if (tx_start_o) begin
        seen = 1;
        break;
      end
      cyc();
    end
    check("reply_strobe_seen", 8'(seen), 8'h01);
    cyc();
    check("reply_held_data", tx_data_o, reply);
    check("reply_start_once", 8'(tx_start_o), 8'h00);
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
  endtask

  initial begin
    rx_ready_i = 1'b1;
    exe_tx_start_i = 1'b1;
    #12;
    check("rst_busy", 8'(busy_o), 8'h00);
    check("rst_grants", {6'd0, ldr_grant_o, exe_grant_o}, 8'h00);
    check("rst_tx", {tx_data_o}, 8'h00);
    check("rst_tx_start", 8'(tx_start_o), 8'h00);
    check("rst_target", 8'(ldr_target_o), 8'h00);
    check("rst_rx_gated", {6'd0, ldr_rx_ready_o, exe_rx_ready_o}, 8'h00);
    rx_ready_i = 1'b0;
    exe_tx_start_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();

    // Load IMEM grant, RX forwarding, loader TX, done with simultaneous RX byte
    send_cmd(8'h1C, 8'hAC);
    check("imem_grant", {6'd0, ldr_grant_o, exe_grant_o}, 8'h02);
    check("imem_target", 8'(ldr_target_o), 8'h00);
    check("imem_busy", 8'(busy_o), 8'h01);
    ldrq.push_back(8'h12);
    rx_data_i = 8'h12;
    rx_ready_i = 1'b1;
    #1;
    check("ldr_rx_comb", {6'd0, ldr_rx_ready_o, exe_rx_ready_o}, 8'h02);
    cyc();
    rx_ready_i = 1'b0;
    txq.push_back(8'hF1);
    ldr_tx_data_i = 8'hF1;
    ldr_tx_start_i = 1'b1;
    exe_tx_data_i = 8'h99;
    exe_tx_start_i = 1'b1;
    #1;
    check("ldr_tx_data", tx_data_o, 8'hF1);
    check("ldr_tx_start", 8'(tx_start_o), 8'h01);
    cyc();
    ldr_tx_start_i = 1'b0;
    #1;
    check("ldr_tx_start_low", 8'(tx_start_o), 8'h00);
    exe_tx_start_i = 1'b0;
    ldrq.push_back(8'h34);
    rx_data_i = 8'h34;
    rx_ready_i = 1'b1;
    ldr_done_i = 1'b1;
    cyc();
    rx_ready_i = 1'b0;
    check("release_grant", 8'(ldr_grant_o), 8'h00);
    check("release_busy", 8'(busy_o), 8'h01);
    cyc();
    check("release_idle", 8'(busy_o), 8'h00);
    ldr_done_i = 1'b0;
    cyc();

    // Load DMEM, done held three cycles
    send_cmd(8'h1D, 8'hAC);
    check("dmem_grant", 8'(ldr_grant_o), 8'h01);
    check("dmem_target", 8'(ldr_target_o), 8'h01);
    ldr_done_i = 1'b1;
    cyc();
    check("dmem_grant_low", 8'(ldr_grant_o), 8'h00);
    cyc();
    check("dmem_idle", 8'(busy_o), 8'h00);
    cyc();
    ldr_done_i = 1'b0;
    check("dmem_target_kept", 8'(ldr_target_o), 8'h01);
    check("dmem_no_regrant", 8'(ldr_grant_o), 8'h00);

    // Unknown command NAK, then exec grant
    send_cmd(8'h55, 8'hEE);
    check("nak_busy", 8'(busy_o), 8'h00);
    check("nak_grants", {6'd0, ldr_grant_o, exe_grant_o}, 8'h00);
    send_cmd(8'hE0, 8'hAC);
    check("exe_grant", {6'd0, ldr_grant_o, exe_grant_o}, 8'h01);
    exeq.push_back(8'h77);
    pulse_rx(8'h77);
    txq.push_back(8'h5A);
    exe_tx_data_i = 8'h5A;
    exe_tx_start_i = 1'b1;
    ldr_tx_data_i = 8'h11;
    ldr_tx_start_i = 1'b1;
    #1;
    check("exe_tx_data", tx_data_o, 8'h5A);
    cyc();
    exe_tx_start_i = 1'b0;
    ldr_tx_start_i = 1'b0;

    // Async reset mid-grant drops everything without a clock edge
    #2;
    rst_ni = 1'b0;
    rx_ready_i = 1'b1;
    exe_tx_start_i = 1'b1;
    #1;
    check("arst_exe_grant", 8'(exe_grant_o), 8'h00);
    check("arst_busy", 8'(busy_o), 8'h00);
    check("arst_tx_start", 8'(tx_start_o), 8'h00);
    check("arst_exe_rx", 8'(exe_rx_ready_o), 8'h00);
    rx_ready_i = 1'b0;
    exe_tx_start_i = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();
    send_cmd(8'h1C, 8'hAC);
    check("post_rst_grant", 8'(ldr_grant_o), 8'h01);
    check("post_rst_target", 8'(ldr_target_o), 8'h00);
    ldr_done_i = 1'b1;
    cyc();
    cyc();
    ldr_done_i = 1'b0;

    // RX strobe while waiting for the reply is dropped and leaves cmd untouched
    txq.push_back(8'hAC);
    pulse_rx(8'h1D);
    cyc();
    rx_data_i = 8'h55;
    rx_ready_i = 1'b1;
    #1;
    check("wait_rx_gated", {6'd0, ldr_rx_ready_o, exe_rx_ready_o}, 8'h00);
    cyc();
    rx_ready_i = 1'b0;
    check("wait_tx_held", tx_data_o, 8'hAC);
    tx_done_i = 1'b1;
    cyc();
    tx_done_i = 1'b0;
    check("wait_cmd_kept_grant", 8'(ldr_grant_o), 8'h01);
    check("wait_cmd_kept_target", 8'(ldr_target_o), 8'h01);
    ldr_done_i = 1'b1;
    cyc();
    cyc();
    ldr_done_i = 1'b0;
    cyc();

    check("txq_drained", 8'(txq.size()), 8'h00);
    check("ldrq_drained", 8'(ldrq.size()), 8'h00);
    check("exeq_drained", 8'(exeq.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
